rob_queue: RTL and testbench

ROB_QUEUE -- requirements
Module: rob_queue

---
 rtl/rob_queue.sv | 175 +++++++++++++++++
 tb/tb_rob_queue.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_queue.sv
// Reorder buffer: in-order dispatch and commit over a circular buffer, with CDB writeback and mispredict flush.
// Optional operand forwarding read ports are enabled with `define ROB_FWD_EN.
module rob_queue #(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned TAG_W     = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             disp_valid_in,
    output logic             disp_ready_out,
    input  logic [1:0]       disp_type_in,
    input  logic [4:0]       disp_rd_in,
    input  logic [31:0]      disp_pc_in,
    output logic [TAG_W-1:0] disp_tag_out,
    input  logic             cdb_valid_in,
    input  logic [TAG_W-1:0] cdb_tag_in,
    input  logic [31:0]      cdb_value_in,
    input  logic             cdb_mispred_in,
    input  logic [31:0]      cdb_target_in,
    input  logic             commit_ready_in,
    output logic             commit_valid_out,
    output logic [TAG_W-1:0] commit_tag_out,
    output logic [1:0]       commit_type_out,
    output logic [4:0]       commit_rd_out,
    output logic [31:0]      commit_value_out,
    output logic             flush_out,
    output logic [31:0]      flush_pc_out,
    output logic [TAG_W:0]   count_out
`ifdef ROB_FWD_EN
    ,
    input  logic [TAG_W-1:0] fwd_tag1_in,
    input  logic [TAG_W-1:0] fwd_tag2_in,
    output logic             fwd_ready1_out,
    output logic             fwd_ready2_out,
    output logic [31:0]      fwd_value1_out,
    output logic [31:0]      fwd_value2_out
`endif
);

    localparam int unsigned CNT_W = TAG_W + 1;

    typedef struct packed {
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] value;
        logic [31:0] target;
    } rob_entry_t;

    rob_entry_t           entry_q [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] busy_q;
    logic [ROB_DEPTH-1:0] ready_q;
    logic [ROB_DEPTH-1:0] mispred_q;
    logic [TAG_W-1:0]     head_q;
    logic [TAG_W-1:0]     tail_q;
    logic [CNT_W-1:0]     count_q;

    logic commit_go_c;
    logic flush_c;
    logic disp_go_c;
    logic cdb_go_c;
    logic [31:0] head_pc_unused;

    // Handshake decode, all from registered state plus this cycle's requests
    always_comb begin
        commit_go_c    = rdy_in && busy_q[head_q] && ready_q[head_q] && commit_ready_in;
        flush_c        = commit_go_c && mispred_q[head_q];
        disp_ready_out = (count_q < CNT_W'(ROB_DEPTH)) && !flush_c;
        disp_go_c      = disp_valid_in && disp_ready_out && rdy_in;
        cdb_go_c       = cdb_valid_in && rdy_in && !flush_c && busy_q[cdb_tag_in];
    end

    assign disp_tag_out   = tail_q;
    assign count_out      = count_q;
    // Per-entry PC is kept only for debug probing
    assign head_pc_unused = entry_q[head_q].pc;

    // Entry payload storage; validity is tracked by busy_q so no reset is needed
    always_ff @(posedge clk_in) begin
        if (disp_go_c) begin
            entry_q[tail_q].typ <= disp_type_in;
            entry_q[tail_q].rd  <= disp_rd_in;
            entry_q[tail_q].pc  <= disp_pc_in;
        end
        if (cdb_go_c) begin
            entry_q[cdb_tag_in].value  <= cdb_value_in;
            entry_q[cdb_tag_in].target <= cdb_target_in;
        end
    end

    // Control state and registered commit/flush outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q           <= '0;
            ready_q          <= '0;
            mispred_q        <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            commit_valid_out <= 1'b0;
            commit_tag_out   <= '0;
            commit_type_out  <= '0;
            commit_rd_out    <= '0;
            commit_value_out <= '0;
            flush_out        <= 1'b0;
            flush_pc_out     <= '0;
        end else begin
            commit_valid_out <= 1'b0;
            flush_out        <= 1'b0;
            if (flush_c) begin
                busy_q    <= '0;
                ready_q   <= '0;
                mispred_q <= '0;
                head_q    <= '0;
                tail_q    <= '0;
                count_q   <= '0;
            end else begin
                if (disp_go_c) begin
                    busy_q[tail_q]    <= 1'b1;
                    ready_q[tail_q]   <= 1'b0;
                    mispred_q[tail_q] <= 1'b0;
                    tail_q            <= tail_q + TAG_W'(1);
                end
                if (cdb_go_c) begin
                    ready_q[cdb_tag_in]   <= 1'b1;
                    mispred_q[cdb_tag_in] <= cdb_mispred_in;
                end
                // Commit release comes last so it wins over a stray CDB to the head
                if (commit_go_c) begin
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                    head_q          <= head_q + TAG_W'(1);
                end
                if (disp_go_c && !commit_go_c) begin
                    count_q <= count_q + CNT_W'(1);
                end else if (!disp_go_c && commit_go_c) begin
                    count_q <= count_q - CNT_W'(1);
                end
            end
            if (commit_go_c) begin
                commit_valid_out <= 1'b1;
                commit_tag_out   <= head_q;
                commit_type_out  <= entry_q[head_q].typ;
                commit_rd_out    <= entry_q[head_q].rd;
                commit_value_out <= entry_q[head_q].value;
            end
            if (flush_c) begin
                flush_out    <= 1'b1;
                flush_pc_out <= entry_q[head_q].target;
            end
        end
    end

`ifdef ROB_FWD_EN
    // Operand lookup with same-cycle CDB bypass
    always_comb begin
        fwd_ready1_out = ready_q[fwd_tag1_in];
        fwd_value1_out = entry_q[fwd_tag1_in].value;
        fwd_ready2_out = ready_q[fwd_tag2_in];
        fwd_value2_out = entry_q[fwd_tag2_in].value;
        if (cdb_go_c && (cdb_tag_in == fwd_tag1_in)) begin
            fwd_ready1_out = 1'b1;
            fwd_value1_out = cdb_value_in;
        end
        if (cdb_go_c && (cdb_tag_in == fwd_tag2_in)) begin
            fwd_ready2_out = 1'b1;
            fwd_value2_out = cdb_value_in;
        end
    end
`else
    // No operand forwarding ports in this build
`endif

endmodule

// File: tb/tb_rob_queue.sv
// Directed self-checking bench for rob_queue: fill, ordered commit, full-buffer wrap, stall, reset, flush.
module tb_rob_queue;

    localparam int unsigned ROB_DEPTH = 16;
    localparam int unsigned TAG_W     = 4;

    logic             clk_in;
    logic             rst_in;
    logic             rdy_in;
    logic             disp_valid_in;
    logic             disp_ready_out;
    logic [1:0]       disp_type_in;
    logic [4:0]       disp_rd_in;
    logic [31:0]      disp_pc_in;
    logic [TAG_W-1:0] disp_tag_out;
    logic             cdb_valid_in;
    logic [TAG_W-1:0] cdb_tag_in;
    logic [31:0]      cdb_value_in;
    logic             cdb_mispred_in;
    logic [31:0]      cdb_target_in;
    logic             commit_ready_in;
    logic             commit_valid_out;
    logic [TAG_W-1:0] commit_tag_out;
    logic [1:0]       commit_type_out;
    logic [4:0]       commit_rd_out;
    logic [31:0]      commit_value_out;
    logic             flush_out;
    logic [31:0]      flush_pc_out;
    logic [TAG_W:0]   count_out;
`ifdef ROB_FWD_EN
    logic [TAG_W-1:0] fwd_tag1_in;
    logic [TAG_W-1:0] fwd_tag2_in;
    logic             fwd_ready1_out;
    logic             fwd_ready2_out;
    logic [31:0]      fwd_value1_out;
    logic [31:0]      fwd_value2_out;
`endif

    int n_vec;
    int n_err;

    rob_queue #(.ROB_DEPTH(ROB_DEPTH), .TAG_W(TAG_W)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .disp_valid_in   (disp_valid_in),
        .disp_ready_out  (disp_ready_out),
        .disp_type_in    (disp_type_in),
        .disp_rd_in      (disp_rd_in),
        .disp_pc_in      (disp_pc_in),
        .disp_tag_out    (disp_tag_out),
        .cdb_valid_in    (cdb_valid_in),
        .cdb_tag_in      (cdb_tag_in),
        .cdb_value_in    (cdb_value_in),
        .cdb_mispred_in  (cdb_mispred_in),
        .cdb_target_in   (cdb_target_in),
        .commit_ready_in (commit_ready_in),
        .commit_valid_out(commit_valid_out),
        .commit_tag_out  (commit_tag_out),
        .commit_type_out (commit_type_out),
        .commit_rd_out   (commit_rd_out),
        .commit_value_out(commit_value_out),
        .flush_out       (flush_out),
        .flush_pc_out    (flush_pc_out),
        .count_out       (count_out)
`ifdef ROB_FWD_EN
        ,
        .fwd_tag1_in     (fwd_tag1_in),
        .fwd_tag2_in     (fwd_tag2_in),
        .fwd_ready1_out  (fwd_ready1_out),
        .fwd_ready2_out  (fwd_ready2_out),
        .fwd_value1_out  (fwd_value1_out),
        .fwd_value2_out  (fwd_value2_out)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sampling point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_disp(input logic v, input logic [1:0] t, input logic [4:0] rd);
        disp_valid_in = v;
        disp_type_in  = t;
        disp_rd_in    = rd;
        disp_pc_in    = 32'h400 + 32'(rd) * 4;
    endtask

    task automatic set_cdb(input logic v, input logic [3:0] tag, input logic [31:0] val,
                           input logic mp, input logic [31:0] tgt);
        cdb_valid_in   = v;
        cdb_tag_in     = tag;
        cdb_value_in   = val;
        cdb_mispred_in = mp;
        cdb_target_in  = tgt;
    endtask

    task automatic check_commit(input string tag, input logic [3:0] t, input logic [1:0] ty,
                                input logic [4:0] rd, input logic [31:0] val);
        check({tag, "_valid"}, 32'(commit_valid_out), 32'd1);
        check({tag, "_tag"},   32'(commit_tag_out),   32'(t));
        check({tag, "_type"},  32'(commit_type_out),  32'(ty));
        check({tag, "_rd"},    32'(commit_rd_out),    32'(rd));
        check({tag, "_value"}, commit_value_out,      val);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        commit_ready_in = 1'b0;
        set_disp(1'b0, 2'd0, 5'd0);
        set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
`ifdef ROB_FWD_EN
        fwd_tag1_in = 4'd0;
        fwd_tag2_in = 4'd0;
`endif
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_count",     32'(count_out),        32'd0);
        check("rst_cvalid",    32'(commit_valid_out), 32'd0);
        check("rst_flush",     32'(flush_out),        32'd0);
        check("rst_flush_pc",  flush_pc_out,          32'd0);
        check("rst_cvalue",    commit_value_out,      32'd0);
        check("rst_disp_rdy",  32'(disp_ready_out),   32'd1);
        check("rst_disp_tag",  32'(disp_tag_out),     32'd0);
        rst_in = 1'b1;

        // Fill all 16 entries with no writeback
        for (int i = 0; i < 16; i++) begin
            set_disp(1'b1, 2'd1, 5'(i));
            #1;
            check($sformatf("fill_tag%0d", i), 32'(disp_tag_out), 32'(i));
            check($sformatf("fill_rdy%0d", i), 32'(disp_ready_out), 32'd1);
            tick();
        end
        check("full_count", 32'(count_out),      32'd16);
        check("full_rdy",   32'(disp_ready_out), 32'd0);
        tick();
        set_disp(1'b0, 2'd0, 5'd0);
        check("full_refuse_count", 32'(count_out),    32'd16);
        check("full_refuse_tail",  32'(disp_tag_out), 32'd0);

        // Out-of-order writeback 2,1,0 commits in order 0,1,2
        commit_ready_in = 1'b1;
        set_cdb(1'b1, 4'd2, 32'h22, 1'b0, 32'd0);
        tick();
        check("ooo_a_cvalid", 32'(commit_valid_out), 32'd0);
        set_cdb(1'b1, 4'd1, 32'h11, 1'b0, 32'd0);
        tick();
        check("ooo_b_cvalid", 32'(commit_valid_out), 32'd0);
        set_cdb(1'b1, 4'd0, 32'h100, 1'b0, 32'd0);
        tick();
        check("ooo_c_cvalid", 32'(commit_valid_out), 32'd0);
        set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        tick();
        check_commit("commit0", 4'd0, 2'd1, 5'd0, 32'h100);
        check("commit0_count", 32'(count_out), 32'd15);
        tick();
        check_commit("commit1", 4'd1, 2'd1, 5'd1, 32'h11);
        tick();
        check_commit("commit2", 4'd2, 2'd1, 5'd2, 32'h22);
        check("commit2_flush", 32'(flush_out), 32'd0);
        tick();
        check("commit_idle", 32'(commit_valid_out), 32'd0);
        check("commit_idle_count", 32'(count_out), 32'd13);
        commit_ready_in = 1'b0;

        // Refill to full across the wrap, then commit and dispatch in one cycle
        for (int i = 0; i < 3; i++) begin
            set_disp(1'b1, 2'd1, 5'(20 + i));
            #1;
            check($sformatf("wrap_tag%0d", i), 32'(disp_tag_out), 32'(i));
            tick();
        end
        set_disp(1'b0, 2'd0, 5'd0);
        check("wrap_full", 32'(count_out), 32'd16);
        set_cdb(1'b1, 4'd3, 32'h33, 1'b0, 32'd0);
        tick();
        set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        set_disp(1'b1, 2'd1, 5'd9);
        commit_ready_in = 1'b1;
        #1;
        check("both_disp_rdy", 32'(disp_ready_out), 32'd0);
        tick();
        check_commit("both_commit", 4'd3, 2'd1, 5'd3, 32'h33);
        check("both_count", 32'(count_out),    32'd15);
        check("both_tail",  32'(disp_tag_out), 32'd3);
        commit_ready_in = 1'b0;
        #1;
        check("after_disp_rdy", 32'(disp_ready_out), 32'd1);
        tick();
        set_disp(1'b0, 2'd0, 5'd0);
        check("after_count", 32'(count_out),    32'd16);
        check("after_tail",  32'(disp_tag_out), 32'd4);
        check("after_cvalid", 32'(commit_valid_out), 32'd0);

        // rdy_in low for three cycles freezes everything
        set_cdb(1'b1, 4'd4, 32'h44, 1'b0, 32'd0);
        tick();
        rdy_in = 1'b0;
        commit_ready_in = 1'b1;
        set_disp(1'b1, 2'd1, 5'd11);
        set_cdb(1'b1, 4'd5, 32'h55, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_cvalid%0d", i), 32'(commit_valid_out), 32'd0);
            check($sformatf("stall_count%0d", i),  32'(count_out),        32'd16);
            check($sformatf("stall_tail%0d", i),   32'(disp_tag_out),     32'd4);
        end
        rdy_in = 1'b1;
        set_disp(1'b0, 2'd0, 5'd0);
        set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        tick();
        check_commit("resume", 4'd4, 2'd1, 5'd4, 32'h44);
        check("resume_count", 32'(count_out), 32'd15);
        tick();
        check("resume_tag5_held", 32'(commit_valid_out), 32'd0);

        // Reset asserted while a commit pulse is on the outputs
        set_cdb(1'b1, 4'd5, 32'h5A, 1'b0, 32'd0);
        tick();
        set_cdb(1'b1, 4'd6, 32'h6A, 1'b0, 32'd0);
        tick();
        check("pre_rst_commit", 32'(commit_valid_out), 32'd1);
        set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        rst_in = 1'b0;
        #1;
        check("midrst_cvalid", 32'(commit_valid_out), 32'd0);
        check("midrst_count",  32'(count_out),        32'd0);
        check("midrst_tail",   32'(disp_tag_out),     32'd0);
        #1;
        rst_in = 1'b1;
        tick();
        check("postrst_cvalid", 32'(commit_valid_out), 32'd0);

        // Mispredicted branch at tag 1 flushes after tag 0 commits
        set_disp(1'b1, 2'd1, 5'd3);
        tick();
        set_disp(1'b1, 2'd2, 5'd0);
        tick();
        set_disp(1'b0, 2'd0, 5'd0);
        set_cdb(1'b1, 4'd0, 32'h55, 1'b0, 32'd0);
        tick();
        check("br_early", 32'(commit_valid_out), 32'd0);
        set_cdb(1'b1, 4'd1, 32'h0, 1'b1, 32'h1000);
        tick();
        check_commit("br_c0", 4'd0, 2'd1, 5'd3, 32'h55);
        check("br_c0_flush", 32'(flush_out), 32'd0);
        check("br_c0_count", 32'(count_out), 32'd1);
        set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        set_disp(1'b1, 2'd1, 5'd7);
        #1;
        check("br_flush_disp_rdy", 32'(disp_ready_out), 32'd0);
        tick();
        check_commit("br_c1", 4'd1, 2'd2, 5'd0, 32'h0);
        check("br_flush",    32'(flush_out),    32'd1);
        check("br_flush_pc", flush_pc_out,      32'h1000);
        check("br_count",    32'(count_out),    32'd0);
        check("br_tail",     32'(disp_tag_out), 32'd0);
        #1;
        check("br_next_rdy", 32'(disp_ready_out), 32'd1);
        tick();
        set_disp(1'b0, 2'd0, 5'd0);
        check("br_next_count",  32'(count_out),        32'd1);
        check("br_next_tail",   32'(disp_tag_out),     32'd1);
        check("br_flush_clear", 32'(flush_out),        32'd0);
        check("br_cvalid_clr",  32'(commit_valid_out), 32'd0);

`ifdef ROB_FWD_EN
        commit_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_disp(1'b1, 2'd1, 5'(12 + i));
            tick();
        end
        set_disp(1'b0, 2'd0, 5'd0);
        fwd_tag1_in = 4'd3;
        fwd_tag2_in = 4'd2;
        set_cdb(1'b1, 4'd3, 32'hABCD, 1'b0, 32'd0);
        #1;
        check("fwd_byp_rdy1", 32'(fwd_ready1_out), 32'd1);
        check("fwd_byp_val1", fwd_value1_out,      32'hABCD);
        check("fwd_byp_rdy2", 32'(fwd_ready2_out), 32'd0);
        tick();
        set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        #1;
        check("fwd_reg_rdy1", 32'(fwd_ready1_out), 32'd1);
        check("fwd_reg_val1", fwd_value1_out,      32'hABCD);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
